// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light mode scheduler.
// Contents: light encodings, scheduler state enum, datapath widths and the
// helper that chooses the phase handed to the incoming mode.
package tl_pkg;

    localparam int LIGHT_W = 2;
    localparam int TIME_W  = 5;

    typedef enum logic [1:0] {
        RED       = 2'b00,
        YELLOW    = 2'b01,
        GREEN     = 2'b10,
        UNDEFINED = 2'b11
    } light_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYNC = 2'b01,
        RUN  = 2'b10
    } sched_state_t;

    // An UNDEFINED phase is replaced by YELLOW so the incoming mode starts in RED.
    function automatic logic [LIGHT_W-1:0] handover_phase(input logic [LIGHT_W-1:0] s);
        if (s == UNDEFINED) begin
            handover_phase = YELLOW;
        end else begin
            handover_phase = s;
        end
    endfunction

endpackage

// File: rtl/mode_scheduler_edge_detect.sv
// Registered rising-edge detector with synchronous clear.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr_i     - synchronous clear of the history bit
//   d_i       - monitored level
//   rise_o    - high while d_i is 1 and the stored previous value is 0
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;
    logic prev_d;

    // Next value of the history bit; a clear makes a held-high input count as an edge.
    always_comb begin
        if (clr_i) begin
            prev_d = 1'b0;
        end else begin
            prev_d = d_i;
        end
    end

    // History register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/mode_scheduler.sv
// Top-level sequencer for the traffic-light mode units.
// Owns the one-hot enb vector and the shared set line, applies mode-change
// requests only at the active mode's phase boundary (feedback rising edge),
// hands the ended phase to the next mode over last_state, and muxes the
// active mode's light/lightTime onto the display outputs.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   tick_1s                     - one-clk pulse per second
//   mode_req, mode_req_valid    - mode-change request and its strobe
//   feedback                    - per-mode phase-boundary level
//   cur_state_in, light_in      - packed 2-bit per-mode currentState / light
//   light_time_in               - packed 5-bit per-mode lightTime
//   enb, set                    - one-hot enable and shared set (RUN only)
//   last_state                  - phase handed to the incoming mode
//   active_mode, switching      - current/target mode, high in IDLE and SYNC
//   light, light_time           - displayed light and remaining time
// Optional build macro MODE_SCHED_WATCHDOG_EN adds a tick watchdog that forces
// a pending handover after WDOG_TICKS ticks and pulses wdog_fire.
module mode_scheduler
    import tl_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int DEFAULT_MODE = 0,
    parameter int SYNC_TICKS   = 2,
    parameter int WDOG_TICKS   = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick_1s,
    input  logic [1:0]                 mode_req,
    input  logic                       mode_req_valid,
    input  logic [NUM_MODES-1:0]       feedback,
    input  logic [2*NUM_MODES-1:0]     cur_state_in,
    input  logic [2*NUM_MODES-1:0]     light_in,
    input  logic [5*NUM_MODES-1:0]     light_time_in,
    output logic [NUM_MODES-1:0]       enb,
    output logic                       set,
    output logic [LIGHT_W-1:0]         last_state,
    output logic [1:0]                 active_mode,
    output logic                       switching,
    output logic [LIGHT_W-1:0]         light,
    output logic [TIME_W-1:0]          light_time
`ifdef MODE_SCHED_WATCHDOG_EN
    ,
    output logic                       wdog_fire
`endif
);

    localparam int SYNC_CNT_W = $clog2(SYNC_TICKS + 1);

    sched_state_t            state_q, state_d;
    logic [1:0]              active_q, active_d;
    logic [LIGHT_W-1:0]      last_state_q, last_state_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [1:0]              pend_idx_q, pend_idx_d;
    logic [SYNC_CNT_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic [NUM_MODES-1:0]    enb_q, enb_d;
    logic                    set_q, set_d;

    logic [NUM_MODES-1:0]    sel_oh_s;
    logic                    fb_sel_s;
    logic                    fb_rise_s;
    logic                    fb_clr_s;
    logic [LIGHT_W-1:0]      cur_sel_s;
    logic [LIGHT_W-1:0]      light_sel_s;
    logic [TIME_W-1:0]       time_sel_s;
    logic                    req_ok_s;
    logic                    wdog_hit_s;

    // Select the active mode's slices with an AND-OR mux.
    always_comb begin
        fb_sel_s    = 1'b0;
        cur_sel_s   = {LIGHT_W{1'b0}};
        light_sel_s = {LIGHT_W{1'b0}};
        time_sel_s  = {TIME_W{1'b0}};
        for (int i = 0; i < NUM_MODES; i++) begin
            sel_oh_s[i] = (active_q == 2'(i));
            fb_sel_s    = fb_sel_s    | (feedback[i] & sel_oh_s[i]);
            cur_sel_s   = cur_sel_s   | (cur_state_in[2*i +: 2] & {LIGHT_W{sel_oh_s[i]}});
            light_sel_s = light_sel_s | (light_in[2*i +: 2] & {LIGHT_W{sel_oh_s[i]}});
            time_sel_s  = time_sel_s  | (light_time_in[5*i +: 5] & {TIME_W{sel_oh_s[i]}});
        end
    end

    // The detector history stays cleared outside RUN so it restarts on RUN entry.
    assign fb_clr_s = (state_q != RUN);

    edge_detect u_fb_edge (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (fb_clr_s),
        .d_i    (fb_sel_s),
        .rise_o (fb_rise_s)
    );

`ifdef MODE_SCHED_WATCHDOG_EN
    localparam int WDOG_CNT_W = $clog2(WDOG_TICKS + 1);

    logic [WDOG_CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic                  wdog_fire_q, wdog_fire_d;

    // Watchdog: counts ticks while a request waits in RUN without a phase boundary.
    always_comb begin
        wdog_hit_s = (state_q == RUN) && pend_valid_q && tick_1s && !fb_rise_s &&
                     (wdog_cnt_q == WDOG_CNT_W'(WDOG_TICKS - 1));
        if ((state_q != RUN) || fb_rise_s || wdog_hit_s) begin
            wdog_cnt_d = {WDOG_CNT_W{1'b0}};
        end else if (pend_valid_q && tick_1s) begin
            wdog_cnt_d = wdog_cnt_q + WDOG_CNT_W'(1);
        end else begin
            wdog_cnt_d = wdog_cnt_q;
        end
        wdog_fire_d = wdog_hit_s;
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q  <= {WDOG_CNT_W{1'b0}};
            wdog_fire_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_fire_q <= wdog_fire_d;
        end
    end

    assign wdog_fire = wdog_fire_q;
`else
    assign wdog_hit_s = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            active_q     <= 2'(DEFAULT_MODE);
            last_state_q <= YELLOW;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= 2'b00;
            sync_cnt_q   <= {SYNC_CNT_W{1'b0}};
            enb_q        <= {NUM_MODES{1'b0}};
            set_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            last_state_q <= last_state_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            sync_cnt_q   <= sync_cnt_d;
            enb_q        <= enb_d;
            set_q        <= set_d;
        end
    end

    // Next-state, handover and request bookkeeping.
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        last_state_d = last_state_q;
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
        sync_cnt_d   = sync_cnt_q;
        case (state_q)
            IDLE: begin
                state_d    = SYNC;
                active_d   = 2'(DEFAULT_MODE);
                sync_cnt_d = {SYNC_CNT_W{1'b0}};
            end
            SYNC: begin
                if (sync_cnt_q == SYNC_CNT_W'(SYNC_TICKS)) begin
                    state_d    = RUN;
                    sync_cnt_d = {SYNC_CNT_W{1'b0}};
                end else if (tick_1s) begin
                    sync_cnt_d = sync_cnt_q + SYNC_CNT_W'(1);
                end else begin
                    sync_cnt_d = sync_cnt_q;
                end
            end
            RUN: begin
                if (fb_rise_s && pend_valid_q) begin
                    last_state_d = handover_phase(cur_sel_s);
                    active_d     = pend_idx_q;
                    pend_valid_d = 1'b0;
                    state_d      = SYNC;
                    sync_cnt_d   = {SYNC_CNT_W{1'b0}};
                end else if (wdog_hit_s) begin
                    last_state_d = YELLOW;
                    active_d     = pend_idx_q;
                    pend_valid_d = 1'b0;
                    state_d      = SYNC;
                    sync_cnt_d   = {SYNC_CNT_W{1'b0}};
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Compared against the post-handover target so a simultaneous request
        // becomes the new pending one unless it names the mode being entered.
        req_ok_s = mode_req_valid &&
                   ({1'b0, mode_req} < 3'(NUM_MODES)) &&
                   (mode_req != active_d);
        pend_valid_d = pend_valid_d | req_ok_s;
        pend_idx_d   = req_ok_s ? mode_req : pend_idx_d;
    end

    // Registered enable/set decoded from the next state.
    always_comb begin
        set_d = (state_d == RUN);
        for (int i = 0; i < NUM_MODES; i++) begin
            enb_d[i] = (state_d == RUN) && (active_d == 2'(i));
        end
    end

    assign enb         = enb_q;
    assign set         = set_q;
    assign last_state  = last_state_q;
    assign active_mode = active_q;
    assign switching   = (state_q != RUN);
    assign light       = (state_q == RUN) ? light_sel_s : RED;
    assign light_time  = (state_q == RUN) ? time_sel_s : {TIME_W{1'b0}};

endmodule

// File: tb/tb_mode_scheduler.sv
// Directed self-checking bench for mode_scheduler (4-mode instance plus a
// 3-mode instance for the out-of-range request case).
module tb_mode_scheduler;

    logic        clk;
    logic        rst;
    logic        tick_1s;
    logic [1:0]  mode_req;
    logic        mode_req_valid;
    logic [3:0]  feedback;
    logic [7:0]  cur_state_in;
    logic [7:0]  light_in;
    logic [19:0] light_time_in;

    logic [3:0]  enb;
    logic        set;
    logic [1:0]  last_state;
    logic [1:0]  active_mode;
    logic        switching;
    logic [1:0]  light;
    logic [4:0]  light_time;

    logic [2:0]  enb3;
    logic        set3;
    logic [1:0]  last_state3;
    logic [1:0]  active_mode3;
    logic        switching3;
    logic [1:0]  light3;
    logic [4:0]  light_time3;

`ifdef MODE_SCHED_WATCHDOG_EN
    logic        wdog_fire;
    logic        wdog_fire3;
`endif

    int n_checks;
    int n_fail;

    mode_scheduler #(
        .NUM_MODES(4), .DEFAULT_MODE(0), .SYNC_TICKS(2), .WDOG_TICKS(5)
    ) dut (
        .clk(clk), .rst(rst), .tick_1s(tick_1s),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid),
        .feedback(feedback), .cur_state_in(cur_state_in),
        .light_in(light_in), .light_time_in(light_time_in),
        .enb(enb), .set(set), .last_state(last_state),
        .active_mode(active_mode), .switching(switching),
        .light(light), .light_time(light_time)
`ifdef MODE_SCHED_WATCHDOG_EN
        , .wdog_fire(wdog_fire)
`endif
    );

    mode_scheduler #(
        .NUM_MODES(3), .DEFAULT_MODE(0), .SYNC_TICKS(2), .WDOG_TICKS(5)
    ) dut3 (
        .clk(clk), .rst(rst), .tick_1s(tick_1s),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid),
        .feedback(feedback[2:0]), .cur_state_in(cur_state_in[5:0]),
        .light_in(light_in[5:0]), .light_time_in(light_time_in[14:0]),
        .enb(enb3), .set(set3), .last_state(last_state3),
        .active_mode(active_mode3), .switching(switching3),
        .light(light3), .light_time(light_time3)
`ifdef MODE_SCHED_WATCHDOG_EN
        , .wdog_fire(wdog_fire3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_once();
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
    endtask

    // Two ticks then the one extra clock into RUN.
    task automatic sync_wait();
        tick_once();
        clk_n(3);
        tick_once();
        clk_n(1);
    endtask

    task automatic request(input logic [1:0] idx);
        mode_req       = idx;
        mode_req_valid = 1'b1;
        @(negedge clk);
        mode_req_valid = 1'b0;
    endtask

    task automatic fb_pulse(input int idx);
        feedback[idx] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        tick_1s        = 1'b0;
        mode_req       = 2'd0;
        mode_req_valid = 1'b0;
        feedback       = 4'b0000;
        cur_state_in   = 8'b00_00_00_00;
        light_in       = 8'b11_01_00_10;                    // m3=11 m2=01 m1=00 m0=10
        light_time_in  = {5'd4, 5'd2, 5'd9, 5'd7};          // m3=4 m2=2 m1=9 m0=7

        // Reset values
        clk_n(1);
        check_eq("rst_enb", enb, 32'h0);
        check_eq("rst_set", set, 32'h0);
        check_eq("rst_last", last_state, 32'h1);
        check_eq("rst_active", active_mode, 32'h0);
        check_eq("rst_switching", switching, 32'h1);
        check_eq("rst_light", {light, light_time}, 32'h0);

        // IDLE -> SYNC -> RUN mode 0
        rst = 1'b0;
        clk_n(1);
        check_eq("sync_switching", switching, 32'h1);
        tick_once();
        clk_n(3);
        tick_once();
        check_eq("sync_hold_enb", enb, 32'h0);
        clk_n(1);
        check_eq("run0_enb", enb, 32'h1);
        check_eq("run0_set", set, 32'h1);
        check_eq("run0_last", last_state, 32'h1);
        check_eq("run0_switching", switching, 32'h0);
        check_eq("run0_light", light, 32'h2);
        check_eq("run0_time", light_time, 32'd7);

        // Handover 0 -> 2 on feedback[0] with mode 0 in GREEN
        request(2'd2);
        cur_state_in[1:0] = 2'b10;
        fb_pulse(0);
        feedback[0] = 1'b0;
        check_eq("ho02_enb", enb, 32'h0);
        check_eq("ho02_last", last_state, 32'h2);
        check_eq("ho02_active", active_mode, 32'h2);
        check_eq("ho02_light", {light, light_time}, 32'h0);
        sync_wait();
        check_eq("run2_enb", enb, 32'h4);
        check_eq("run2_light", light, 32'h1);
        check_eq("run2_time", light_time, 32'd2);

        // Self-request discarded; feedback without pending does nothing
        request(2'd2);
        fb_pulse(2);
        feedback[2] = 1'b0;
        check_eq("self_req_enb", enb, 32'h4);
        check_eq("self_req_switching", switching, 32'h0);
        clk_n(1);

        // Index 3: valid for 4 modes, out of range for 3 modes
        request(2'd3);
        cur_state_in[5:4] = 2'b00;
        fb_pulse(2);
        feedback[2] = 1'b0;
        check_eq("idx3_active4", active_mode, 32'h3);
        check_eq("idx3_last4", last_state, 32'h0);
        check_eq("idx3_enb3", enb3, 32'h4);
        check_eq("idx3_active3", active_mode3, 32'h2);
        sync_wait();
        check_eq("run3_enb", enb, 32'h8);
        check_eq("run3_time", light_time, 32'd4);

        // Later request overwrites; non-active feedback ignored; UNDEFINED -> YELLOW
        request(2'd1);
        request(2'd0);
        fb_pulse(1);
        feedback[1] = 1'b0;
        check_eq("nonactive_fb_enb", enb, 32'h8);
        cur_state_in[7:6] = 2'b11;
        fb_pulse(3);
        feedback[3] = 1'b0;
        check_eq("overwrite_active", active_mode, 32'h0);
        check_eq("undef_last", last_state, 32'h1);
        sync_wait();
        check_eq("run0b_enb", enb, 32'h1);

        // Simultaneous request and feedback edge
        request(2'd1);
        cur_state_in[1:0] = 2'b00;
        mode_req          = 2'd2;
        mode_req_valid    = 1'b1;
        fb_pulse(0);
        mode_req_valid = 1'b0;
        feedback[0]    = 1'b0;
        check_eq("simul_active", active_mode, 32'h1);
        check_eq("simul_last", last_state, 32'h0);
        sync_wait();
        check_eq("run1_enb", enb, 32'h2);
        cur_state_in[3:2] = 2'b10;
        fb_pulse(1);
        feedback[1] = 1'b0;
        check_eq("simul_pending_active", active_mode, 32'h2);
        check_eq("simul_pending_last", last_state, 32'h2);

        // Request latched during SYNC, serviced after RUN
        request(2'd3);
        sync_wait();
        check_eq("run2b_enb", enb, 32'h4);
        fb_pulse(2);
        feedback[2] = 1'b0;
        check_eq("sync_req_active", active_mode, 32'h3);

        // Request equal to SYNC target discarded
        request(2'd3);
        sync_wait();
        check_eq("run3b_enb", enb, 32'h8);
        fb_pulse(3);
        feedback[3] = 1'b0;
        check_eq("sync_self_enb", enb, 32'h8);
        check_eq("sync_self_active", active_mode, 32'h3);

        // Reset during SYNC toward mode 2
        request(2'd2);
        cur_state_in[7:6] = 2'b10;
        fb_pulse(3);
        feedback[3] = 1'b0;
        tick_once();
        check_eq("pre_rst_last", last_state, 32'h2);
        rst = 1'b1;
        #1;
        check_eq("rst_sync_enb", enb, 32'h0);
        check_eq("rst_sync_active", active_mode, 32'h0);
        check_eq("rst_sync_last", last_state, 32'h1);
        clk_n(1);
        rst = 1'b0;
        clk_n(1);
        sync_wait();
        check_eq("rerun_enb", enb, 32'h1);

        // Reset during RUN drops enb without a clock edge
        rst = 1'b1;
        #1;
        check_eq("rst_run_enb", enb, 32'h0);
        check_eq("rst_run_set", set, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clk_n(1);
        sync_wait();
        check_eq("rerun2_enb", enb, 32'h1);

`ifdef MODE_SCHED_WATCHDOG_EN
        // Watchdog forces handover after 5 ticks without feedback
        cur_state_in[1:0] = 2'b10;
        request(2'd1);
        for (int k = 0; k < 4; k++) begin
            tick_once();
            clk_n(2);
        end
        check_eq("wdog_quiet", wdog_fire, 32'h0);
        check_eq("wdog_quiet_enb", enb, 32'h1);
        tick_once();
        check_eq("wdog_fire", wdog_fire, 32'h1);
        check_eq("wdog_active", active_mode, 32'h1);
        check_eq("wdog_last", last_state, 32'h1);
        check_eq("wdog_switching", switching, 32'h1);
        clk_n(1);
        check_eq("wdog_pulse_end", wdog_fire, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
